i2c_bit_ctrl: RTL
=================

Name: i2c_bit_ctrl

Overview:
Bit-level I2C master sequencer that drives the open-drain SCL/SDA enables. It executes START, STOP, WRITE-bit and READ-bit commands from the byte/command layer over a valid/ready handshake. Phase durations come from the tsusta/tsusto/thdsta/tsudat/tbuf/thigh/tlow register outputs of the I2C register block. It detects arbitration loss and, optionally, honours slave clock stretching.

Parameters:
CNT_W, 32, width of timing inputs and phase counter
SYNC_STAGES, 2, flops in scl_i/sda_i synchronizers (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd  in  2  00 START (incl. repeated), 01 STOP, 10 WRITE, 11 READ
cmd_din  in  1  bit to transmit for WRITE
rsp_valid  out  1  one-cycle pulse: command finished
rsp_dout  out  1  sampled SDA for READ (0 otherwise)
rsp_err  out  1  qualifies rsp_valid: illegal command or arbitration lost
arb_lost  out  1  one-cycle pulse on arbitration loss
busy  out  1  state != IDLE or bus owned (started)
tsusta,tsusto,thdsta,tsudat,tbuf,thigh,tlow  in  CNT_W each  phase lengths in clk cycles
scl_i, sda_i  in  1  raw bus levels
scl_oe, sda_oe  out  1  1 = pull line low

Behaviour:
- Reset: scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_dout=0, rsp_err=0, arb_lost=0, started=0, state IDLE, synchronizers cleared to 1. Reset mid-command aborts immediately; lines are released the next cycle.
- Handshake: cmd_ready=1 only in IDLE. Command is accepted on the edge where cmd_valid&cmd_ready; cmd_ready=0 from the next cycle until the rsp_valid cycle, during which cmd_ready is again 1.
- Phase timing: each phase lasts max(N,1) cycles, where N is the timing value sampled at phase entry. The counter loads N-1 (0 if N==0) and the phase exits on cnt==0. scl_oe/sda_oe are registered and constant within a phase.
- START: if started=1, prefix R_PRE {scl_oe=1,sda_oe=0,tsudat}. Then S_SU {0,0,tsusta}, S_HD {0,1,thdsta}, S_LOW {1,1,tlow}; sets started=1.
- STOP: P_PRE {1,1,tsudat}, P_SU {0,1,tsusto}, P_BUF {0,0,tbuf}; clears started.
- WRITE: W_SU {1,~cmd_din,tsudat}, W_HI {0,~cmd_din,thigh}, W_LO {1,~cmd_din,tlow}.
- READ: same phases and durations as WRITE with sda_oe=0 throughout. rsp_dout = synchronized SDA in the last W_HI cycle.
- Between commands with started=1, SCL is held low (scl_oe=1) and sda_oe holds its last value.
- Illegal command: WRITE/READ/STOP with started=0 produces no bus activity. rsp_valid=1 and rsp_err=1 on the cycle after acceptance.
- Arbitration: in W_HI with cmd_din=1, if synchronized SDA is 0 on any cycle, then next cycle: arb_lost=1, rsp_valid=1, rsp_err=1, scl_oe=sda_oe=0, started=0, IDLE.
- rsp_valid fires in the cycle after the final phase ends, with the state already back in IDLE.

Optional Feature:
I2C_CLK_STRETCH_EN: when defined, W_HI/S_SU/P_SU hold their counter until synchronized SCL reads 1, then count N. Arbitration sampling is gated by SCL high. When undefined, scl_i is ignored and counting starts on phase entry.

Test Plan:
- Timings tsusta=4,thdsta=4,tlow=5,thigh=5,tsudat=2,tsusto=4,tbuf=6; START from idle -> lines released 4 cycles, sda_oe=1 for 9 cycles, scl_oe=1 last 5, single rsp_valid, rsp_err=0, busy=1.
- WRITE din=0 then din=1 -> each bit: scl_oe 1/0/1 for 2/5/5 cycles, sda_oe=1 resp. 0 throughout; no arb_lost.
- READ with sda_i=0 then sda_i=1 held through high phase -> rsp_dout=0 then 1; thigh=0 -> 1-cycle high phase.
- WRITE din=1 with sda_i forced 0 during high -> arb_lost pulse, rsp_err=1, both oe=0; next WRITE -> rsp_err=1 with no line activity.
- STOP then START -> sda_oe released, lines idle 6 cycles (tbuf) before rsp_valid; following START has no R_PRE. With I2C_CLK_STRETCH_EN, scl_i held low 10 cycles in W_HI -> high phase is 10+SYNC_STAGES+5 cycles.
- rst asserted mid-W_HI -> next cycle scl_oe=sda_oe=0, cmd_ready=1, busy=0, no rsp_valid.

Source files
------------

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master sequencer: START/STOP/WRITE/READ over valid/ready, open-drain enables.
// Define I2C_CLK_STRETCH_EN to make SCL-high phases wait for the slave to release SCL.
module i2c_bit_ctrl #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic             cmd_din,
  output logic             rsp_valid,
  output logic             rsp_dout,
  output logic             rsp_err,
  output logic             arb_lost,
  output logic             busy,
  input  logic [CNT_W-1:0] tsusta,
  input  logic [CNT_W-1:0] tsusto,
  input  logic [CNT_W-1:0] thdsta,
  input  logic [CNT_W-1:0] tsudat,
  input  logic [CNT_W-1:0] tbuf,
  input  logic [CNT_W-1:0] thigh,
  input  logic [CNT_W-1:0] tlow,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe
);

  typedef enum logic [3:0] {
    IDLE, R_PRE, S_SU, S_HD, S_LOW, P_PRE, P_SU, P_BUF, W_SU, W_HI, W_LO
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b11;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic               started_q, started_d;
  logic               din_q, din_d, rd_q, rd_d, rbit_q, rbit_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_dout_q, rsp_dout_d;
  logic               rsp_err_q, rsp_err_d, arb_q, arb_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic               scl_s, sda_s, scl_hold, arb_gate, done, wsda;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_CLK_STRETCH_EN
  // SCL-released phases only start counting once the bus actually shows SCL high.
  assign scl_hold = ((state_q == W_HI) || (state_q == S_SU) || (state_q == P_SU)) && !scl_s;
  assign arb_gate = scl_s;
`else
  logic unused_scl;
  assign unused_scl = scl_s;
  assign scl_hold   = 1'b0;
  assign arb_gate   = 1'b1;
`endif

  assign done = (cnt_q == '0) && !scl_hold;

  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    started_d   = started_q;
    din_d       = din_q;
    rd_d        = rd_q;
    rbit_d      = rbit_q;
    rsp_valid_d = 1'b0;
    rsp_dout_d  = 1'b0;
    rsp_err_d   = 1'b0;
    arb_d       = 1'b0;

    if (state_q != IDLE && !scl_hold && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      IDLE: if (cmd_valid) begin
        din_d = cmd_din;
        rd_d  = (cmd == CMD_READ);
        if (cmd == CMD_START)     state_d = started_q ? R_PRE : S_SU;
        else if (!started_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
        else if (cmd == CMD_STOP) state_d = P_PRE;
        else                      state_d = W_SU;
      end
      R_PRE: if (done) state_d = S_SU;
      S_SU:  if (done) state_d = S_HD;
      S_HD:  if (done) state_d = S_LOW;
      S_LOW: if (done) begin
        state_d     = IDLE;
        started_d   = 1'b1;
        rsp_valid_d = 1'b1;
      end
      P_PRE: if (done) state_d = P_SU;
      P_SU:  if (done) state_d = P_BUF;
      P_BUF: if (done) begin
        state_d     = IDLE;
        started_d   = 1'b0;
        rsp_valid_d = 1'b1;
      end
      W_SU:  if (done) state_d = W_HI;
      W_HI: begin
        if (!rd_q && din_q && !sda_s && arb_gate) begin
          state_d     = IDLE;
          scl_oe_d    = 1'b0;
          sda_oe_d    = 1'b0;
          started_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          arb_d       = 1'b1;
        end else if (done) begin
          rbit_d  = sda_s;
          state_d = W_LO;
        end
      end
      W_LO: if (done) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_dout_d  = rd_q & rbit_q;
      end
      default: state_d = IDLE;
    endcase

    // Phase entry: drive the phase's line levels and load its duration.
    wsda = ~din_d & ~rd_d;
    if (state_d != state_q && state_d != IDLE) begin
      case (state_d)
        R_PRE: begin scl_oe_d = 1'b1; sda_oe_d = 1'b0; cnt_d = ld(tsudat); end
        S_SU:  begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; cnt_d = ld(tsusta); end
        S_HD:  begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; cnt_d = ld(thdsta); end
        S_LOW: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; cnt_d = ld(tlow);   end
        P_PRE: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; cnt_d = ld(tsudat); end
        P_SU:  begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; cnt_d = ld(tsusto); end
        P_BUF: begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; cnt_d = ld(tbuf);   end
        W_SU:  begin scl_oe_d = 1'b1; sda_oe_d = wsda; cnt_d = ld(tsudat); end
        W_HI:  begin scl_oe_d = 1'b0; sda_oe_d = wsda; cnt_d = ld(thigh);  end
        W_LO:  begin scl_oe_d = 1'b1; sda_oe_d = wsda; cnt_d = ld(tlow);   end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      started_q   <= 1'b0;
      din_q       <= 1'b0;
      rd_q        <= 1'b0;
      rbit_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      arb_q       <= 1'b0;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      started_q   <= started_d;
      din_q       <= din_d;
      rd_q        <= rd_d;
      rbit_q      <= rbit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_err_q   <= rsp_err_d;
      arb_q       <= arb_d;
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) || started_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_err   = rsp_err_q;
  assign arb_lost  = arb_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule
